// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-bus request/response, decode-side output.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline/bus.
interface fetch_unit_if #(
   parameter int XLEN = 64
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            ireq_valid;
   logic [XLEN-1:0] ireq_addr;
   logic            ireq_ready;
   logic            iresp_valid;
   logic [31:0]     iresp_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_instr;

   modport master (
      input  redirect_valid, redirect_pc, ireq_ready, iresp_valid, iresp_data, out_ready,
      output ireq_valid, ireq_addr, out_valid, out_pc, out_instr
   );

   modport slave (
      output redirect_valid, redirect_pc, ireq_ready, iresp_valid, iresp_data, out_ready,
      input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding bus read, {pc,instr} FIFO to decode; response lands on out one cycle later.
// Decode backpressure fills the FIFO and stalls request issue; redirects flush the FIFO and drop in-flight data.
module fetch_unit #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic          clk,
   input  logic          reset,
   fetch_unit_if.master  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   req_pc_q, req_pc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [XLEN-1:0]   mem_pc_q    [DEPTH];
   logic [31:0]       mem_instr_q [DEPTH];

   logic              ireq_valid_q, ireq_valid_d;
   logic [XLEN-1:0]   ireq_addr_q, ireq_addr_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_pc_q, out_pc_d;
   logic [31:0]       out_instr_q, out_instr_d;

   logic accept;
   logic push;
   logic pop;

   // ireq_valid_q only rises while in REQ with room, so valid&&ready is a legal accept.
   assign accept = ireq_valid_q && bus.ireq_ready;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      push     = 1'b0;
      pop      = 1'b0;

      if (bus.redirect_valid) begin
         pc_d     = bus.redirect_pc & ~XLEN'(3);
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
         case (state_q)
            S_REQ:   state_d = accept ? S_DROP : S_REQ;
            S_WAIT:  state_d = bus.iresp_valid ? S_REQ : S_DROP;
            S_DROP:  state_d = bus.iresp_valid ? S_REQ : S_DROP;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (accept) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + XLEN'(4);
                  state_d  = S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.iresp_valid) begin
                  push    = 1'b1;
                  state_d = S_REQ;
               end
            end
            S_DROP: begin
               if (bus.iresp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
         endcase
         pop = out_valid_q && bus.out_ready;
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      ireq_valid_d = (state_d == S_REQ) && (count_d < CNT_W'(DEPTH));
      ireq_addr_d  = pc_d;
      out_valid_d  = (count_d != '0);
      out_pc_d     = out_pc_q;
      out_instr_d  = out_instr_q;
      // Head bypasses the array when the entry being written becomes the new head.
      if (count_d != '0) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            out_pc_d    = req_pc_q;
            out_instr_d = bus.iresp_data;
         end else begin
            out_pc_d    = mem_pc_q[rd_ptr_d];
            out_instr_d = mem_instr_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         req_pc_q     <= '0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]    <= '0;
            mem_instr_q[i] <= '0;
         end
         ireq_valid_q <= 1'b0;
         ireq_addr_q  <= RESET_PC;
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_instr_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         if (push) begin
            mem_pc_q[wr_ptr_q]    <= req_pc_q;
            mem_instr_q[wr_ptr_q] <= bus.iresp_data;
         end
         ireq_valid_q <= ireq_valid_d;
         ireq_addr_q  <= ireq_addr_d;
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_instr_q  <= out_instr_d;
      end
   end

   assign bus.ireq_valid = ireq_valid_q;
   assign bus.ireq_addr  = ireq_addr_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_pc     = out_pc_q;
   assign bus.out_instr  = out_instr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, FIFO backpressure, redirect corner cases, async reset.
module tb_fetch_unit;
   localparam int XLEN = 64;
   localparam logic [XLEN-1:0] RST_PC = 64'h8000_0000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   fetch_unit_if #(.XLEN(XLEN)) bus ();

   fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.ireq_ready     = 1'b0;
      bus.iresp_valid    = 1'b0;
      bus.iresp_data     = '0;
      bus.out_ready      = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   // One full request/response round trip with the response one cycle after acceptance.
   task automatic fetch_one(input logic [31:0] data);
      bus.ireq_ready = 1'b1;
      tick();
      bus.ireq_ready  = 1'b0;
      bus.iresp_valid = 1'b1;
      bus.iresp_data  = data;
      tick();
      bus.iresp_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      checks++; if (bus.ireq_valid !== 1'b0) begin failures++; $display("FAIL rst_ireq_valid: got %0b want 0", bus.ireq_valid); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
      checks++; if (bus.out_pc !== 64'h0) begin failures++; $display("FAIL rst_out_pc: got %h want 0", bus.out_pc); end
      checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL rst_out_instr: got %h want 0", bus.out_instr); end
      reset = 1'b1;
      tick();
      checks++; if (bus.ireq_valid !== 1'b1) begin failures++; $display("FAIL rst_first_req: got %0b want 1", bus.ireq_valid); end
      checks++; if (bus.ireq_addr !== RST_PC) begin failures++; $display("FAIL rst_first_addr: got %h want %h", bus.ireq_addr, RST_PC); end
   endtask

   task automatic test_stream();
      logic [XLEN-1:0] exp_pc;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_pc = RST_PC + 64'(4 * i);
         checks++; if (bus.ireq_valid !== 1'b1) begin failures++; $display("FAIL stream_req_valid[%0d]: got %0b want 1", i, bus.ireq_valid); end
         checks++; if (bus.ireq_addr !== exp_pc) begin failures++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, bus.ireq_addr, exp_pc); end
         if (i > 0) begin
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stream_out_valid[%0d]: got %0b want 1", i, bus.out_valid); end
            checks++; if (bus.out_pc !== exp_pc - 64'd4) begin failures++; $display("FAIL stream_out_pc[%0d]: got %h want %h", i, bus.out_pc, exp_pc - 64'd4); end
            checks++; if (bus.out_instr !== 32'h1000_0000 + 32'(i - 1)) begin failures++; $display("FAIL stream_out_instr[%0d]: got %h want %h", i, bus.out_instr, 32'h1000_0000 + 32'(i - 1)); end
         end
         bus.ireq_ready = 1'b1;
         tick();
         bus.ireq_ready = 1'b0;
         checks++; if (bus.ireq_valid !== 1'b0) begin failures++; $display("FAIL stream_wait_req[%0d]: got %0b want 0", i, bus.ireq_valid); end
         checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_wait_out[%0d]: got %0b want 0", i, bus.out_valid); end
         bus.iresp_valid = 1'b1;
         bus.iresp_data  = 32'h1000_0000 + 32'(i);
         tick();
         bus.iresp_valid = 1'b0;
      end
      checks++; if (bus.out_pc !== 64'h8000_0008) begin failures++; $display("FAIL stream_last_pc: got %h want 80000008", bus.out_pc); end
      checks++; if (bus.out_instr !== 32'h1000_0002) begin failures++; $display("FAIL stream_last_instr: got %h want 10000002", bus.out_instr); end
      checks++; if (bus.ireq_addr !== 64'h8000_000C) begin failures++; $display("FAIL stream_next_addr: got %h want 8000000c", bus.ireq_addr); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained: got %0b want 0", bus.out_valid); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_fifo_full();
      do_reset();
      fetch_one(32'hAAAA_0000);
      checks++; if (bus.ireq_valid !== 1'b1) begin failures++; $display("FAIL full_one_entry_req: got %0b want 1", bus.ireq_valid); end
      fetch_one(32'hBBBB_0004);
      checks++; if (bus.ireq_valid !== 1'b0) begin failures++; $display("FAIL full_blocks_req: got %0b want 0", bus.ireq_valid); end
      bus.ireq_ready = 1'b1;
      tick();
      tick();
      bus.ireq_ready = 1'b0;
      checks++; if (bus.ireq_valid !== 1'b0) begin failures++; $display("FAIL full_still_blocked: got %0b want 0", bus.ireq_valid); end
      checks++; if (bus.out_pc !== 64'h8000_0000 || bus.out_instr !== 32'hAAAA_0000) begin failures++; $display("FAIL full_head_stable: got %h/%h want 80000000/aaaa0000", bus.out_pc, bus.out_instr); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0008) begin failures++; $display("FAIL full_pop_req: got %0b/%h want 1/80000008", bus.ireq_valid, bus.ireq_addr); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_0004 || bus.out_instr !== 32'hBBBB_0004) begin failures++; $display("FAIL full_pop_head: got %0b/%h/%h want 1/80000004/bbbb0004", bus.out_valid, bus.out_pc, bus.out_instr); end
      bus.ireq_ready = 1'b1;
      tick();
      bus.ireq_ready  = 1'b0;
      bus.out_ready   = 1'b1;
      bus.iresp_valid = 1'b1;
      bus.iresp_data  = 32'hCCCC_0008;
      tick();
      bus.iresp_valid = 1'b0;
      bus.out_ready   = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_0008 || bus.out_instr !== 32'hCCCC_0008) begin failures++; $display("FAIL pushpop_head: got %0b/%h/%h want 1/80000008/cccc0008", bus.out_valid, bus.out_pc, bus.out_instr); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      fetch_one(32'h1111_0000);
      bus.ireq_ready = 1'b1;
      tick();
      bus.ireq_ready     = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h8000_1002;
      tick();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rdw_flushed: got %0b want 0", bus.out_valid); end
      tick();
      tick();
      checks++; if (bus.ireq_valid !== 1'b0) begin failures++; $display("FAIL rdw_drop_no_req: got %0b want 0", bus.ireq_valid); end
      bus.iresp_valid = 1'b1;
      bus.iresp_data  = 32'hDEAD_BEEF;
      tick();
      bus.iresp_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rdw_stale_dropped: got %0b want 0 (instr %h)", bus.out_valid, bus.out_instr); end
      checks++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_1000) begin failures++; $display("FAIL rdw_new_addr: got %0b/%h want 1/80001000", bus.ireq_valid, bus.ireq_addr); end
      fetch_one(32'h1234_5678);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_1000 || bus.out_instr !== 32'h1234_5678) begin failures++; $display("FAIL rdw_resume: got %0b/%h/%h want 1/80001000/12345678", bus.out_valid, bus.out_pc, bus.out_instr); end
   endtask

   task automatic test_redirect_resp_same();
      do_reset();
      bus.ireq_ready = 1'b1;
      tick();
      bus.ireq_ready     = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h8000_2000;
      bus.iresp_valid    = 1'b1;
      bus.iresp_data     = 32'hDEAD_BEEF;
      tick();
      bus.redirect_valid = 1'b0;
      bus.iresp_valid    = 1'b0;
      checks++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_2000) begin failures++; $display("FAIL rsame_req: got %0b/%h want 1/80002000", bus.ireq_valid, bus.ireq_addr); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rsame_discard: got %0b want 0", bus.out_valid); end
      fetch_one(32'h2222_2222);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_2000 || bus.out_instr !== 32'h2222_2222) begin failures++; $display("FAIL rsame_no_drop: got %0b/%h/%h want 1/80002000/22222222", bus.out_valid, bus.out_pc, bus.out_instr); end
   endtask

   task automatic test_redirect_full();
      do_reset();
      fetch_one(32'hAAAA_AAAA);
      fetch_one(32'hBBBB_BBBB);
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h8000_3000;
      tick();
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rfull_flushed: got %0b want 0", bus.out_valid); end
      checks++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_3000) begin failures++; $display("FAIL rfull_req: got %0b/%h want 1/80003000", bus.ireq_valid, bus.ireq_addr); end
      bus.ireq_ready     = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h8000_4000;
      tick();
      bus.ireq_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      checks++; if (bus.ireq_valid !== 1'b0) begin failures++; $display("FAIL racc_drop_state: got %0b want 0", bus.ireq_valid); end
      bus.iresp_valid = 1'b1;
      bus.iresp_data  = 32'hBAD0_BAD0;
      tick();
      bus.iresp_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL racc_stale: got %0b want 0", bus.out_valid); end
      checks++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_4000) begin failures++; $display("FAIL racc_req: got %0b/%h want 1/80004000", bus.ireq_valid, bus.ireq_addr); end
      fetch_one(32'h3333_3333);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_4000 || bus.out_instr !== 32'h3333_3333) begin failures++; $display("FAIL racc_resume: got %0b/%h/%h want 1/80004000/33333333", bus.out_valid, bus.out_pc, bus.out_instr); end
   endtask

   task automatic test_back_to_back();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h8000_5000;
      tick();
      bus.redirect_pc    = 64'h8000_6007;
      tick();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.ireq_addr !== 64'h8000_6004) begin failures++; $display("FAIL b2b_last_wins: got %h want 80006004", bus.ireq_addr); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_flushed: got %0b want 0", bus.out_valid); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_addr: got %h want fffffffffffffffc", bus.ireq_addr); end
      fetch_one(32'h4444_4444);
      checks++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h0) begin failures++; $display("FAIL wrap_next: got %0b/%h want 1/0", bus.ireq_valid, bus.ireq_addr); end
      checks++; if (bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.out_instr !== 32'h4444_4444) begin failures++; $display("FAIL wrap_out: got %h/%h want fffffffffffffffc/44444444", bus.out_pc, bus.out_instr); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fetch_one(32'h5555_5555);
      bus.ireq_ready = 1'b1;
      tick();
      bus.ireq_ready = 1'b0;
      reset = 1'b0;
      #1;
      checks++; if (bus.ireq_valid !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valids: got %0b/%0b want 0/0", bus.ireq_valid, bus.out_valid); end
      checks++; if (bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0) begin failures++; $display("FAIL midrst_data: got %h/%h want 0/0", bus.out_pc, bus.out_instr); end
      tick();
      reset = 1'b1;
      tick();
      checks++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== RST_PC) begin failures++; $display("FAIL midrst_restart: got %0b/%h want 1/%h", bus.ireq_valid, bus.ireq_addr, RST_PC); end
      bus.iresp_valid = 1'b1;
      bus.iresp_data  = 32'hBADB_AD00;
      tick();
      bus.iresp_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale: got %0b want 0", bus.out_valid); end
      checks++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== RST_PC) begin failures++; $display("FAIL midrst_still_req: got %0b/%h want 1/%h", bus.ireq_valid, bus.ireq_addr, RST_PC); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fifo_full();
      test_redirect_wait();
      test_redirect_resp_same();
      test_redirect_full();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
